rf_dump_unit: RTL
=================

Name: rf_dump_unit

Overview:
Debug scan-out engine that streams the RV32I register file out of the core for end-of-test checking, so results no longer need to be peeked hierarchically from the bench. On a start pulse it requests a core halt, reads x0..x31 through a dedicated debug read port, and emits each register as one beat on a valid/ready stream. It then emits one trailing checksum beat. It sits beside riscv_top's decode stage, which owns the RF, and feeds either the bench monitor or a future UART/JTAG debug transport.

Parameters:
N_REGS, 32, registers dumped, indices 0..N_REGS-1; must equal riscv_defs N_REGISTERS.
XLEN, 32, register and data width.
IDX_W, 5, index width, clog2(N_REGS).

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  1-cycle request to begin a dump; sampled only in IDLE
o_busy  out  1  high from the cycle after an accepted start until the cycle DONE is left
o_halt_req  out  1  asks the core to freeze fetch and RF writes
i_halt_ack  in  1  core frozen; RF contents stable
o_rf_ren  out  1  debug RF read enable
o_rf_raddr  out  IDX_W  debug RF read address
i_rf_rdata  in  XLEN  read data, valid exactly 1 cycle after o_rf_ren
o_dump_valid  out  1  stream beat valid
i_dump_ready  in  1  consumer accepts the beat when valid && ready on the same edge
o_dump_data  out  XLEN  register value or checksum
o_dump_idx  out  IDX_W  register index; 0 on the checksum beat
o_dump_is_sum  out  1  marks the checksum beat
o_dump_last  out  1  high on the checksum beat only
o_done  out  1  1-cycle pulse after the checksum beat is accepted

Behaviour:
- Reset: state IDLE. All outputs 0: o_busy, o_halt_req, o_rf_ren, o_rf_raddr, o_dump_*, o_done. Index counter 0, checksum accumulator 0.
- States: IDLE, HALT_WAIT, READ, CAPTURE, SEND, SEND_SUM, DONE.
- IDLE: on i_start, go to HALT_WAIT. Clear the counter and accumulator. Assert o_halt_req and o_busy from the next cycle.
- HALT_WAIT: hold o_halt_req. On i_halt_ack, go to READ. There is no timeout; the unit waits indefinitely.
- READ: assert o_rf_ren for 1 cycle with o_rf_raddr = counter. Go to CAPTURE.
- CAPTURE: register i_rf_rdata into o_dump_data. Idx 0 is forced to 0 regardless of rdata. Set o_dump_idx = counter and o_dump_valid = 1. Add the value to the accumulator mod 2^XLEN. Go to SEND.
- SEND: o_dump_data, o_dump_idx and o_dump_valid stay stable while valid && !ready.
  - On acceptance with counter == N_REGS-1: go to SEND_SUM.
  - On acceptance otherwise: increment the counter and go to READ.
  - Valid drops in the acceptance cycle's successor, so throughput is 1 beat per 3 cycles with ready tied high.
- SEND_SUM:
  - Present the accumulator with o_dump_is_sum = 1, o_dump_last = 1, o_dump_idx = 0, valid = 1. Hold until accepted.
  - The accumulator is the 32-bit wrapping sum of all emitted register beats; x0 contributes 0.
- DONE: 1 cycle. o_done = 1, o_halt_req deasserts, o_busy deasserts. Return to IDLE.
- i_start outside IDLE is ignored; it is neither queued nor restarted.
- i_halt_ack dropping after HALT_WAIT is ignored; o_halt_req stays high until DONE.
- i_reset mid-dump, in any state, including with valid high: all outputs are 0 on the next cycle and the state is IDLE. A partial stream has no last beat, and the consumer must discard it.
- Counter wrap: the counter never exceeds N_REGS-1. No wrap from 31 to 0 occurs inside a dump.
- o_rf_ren is never asserted outside READ, and the debug read never alters RF state.

Test Plan:
- RF x1..x31 = index*3, x0 rdata returns 0xDEAD (force check), ready tied 1, i_start pulse, ack 2 cycles later -> 32 beats, idx 0..31, data 0,3,..,93; sum beat 0x5D0 (1488) with last=1; o_done one cycle later; halt_req low after DONE.
- Same setup, ready low for 5 cycles on beat idx 7 -> data/idx held stable all 5 cycles; the beat is accepted once; stream is otherwise identical.
- x1..x31 = 0xFFFFFFFF -> sum beat 0xFFFFFFE1, wrapping mod 2^32.
- i_start held high for 40 cycles, ack immediate -> exactly one dump; repeat starts are ignored while busy; a new start after o_done produces a second identical dump.
- Reset asserted during SEND at idx 12 -> next cycle valid=0, halt_req=0, busy=0; a later start dumps from idx 0 with a fresh sum.
- i_halt_ack held 0 for 100 cycles -> o_rf_ren never asserted, no beats, halt_req and busy held high.

Source files
------------

// File: rtl/rf_dump_unit.sv
// rf_dump_unit
// Debug scan-out engine for the RV32I register file. A start pulse halts the
// core, then the engine reads x0..x(N_REGS-1) over a dedicated debug read
// port. Each register goes out as one beat on a valid/ready stream, followed
// by one checksum beat.
//
// Ports:
//   i_clock, i_reset     rising-edge clock, synchronous active-high reset
//   i_start              1-cycle dump request, honoured only in IDLE
//   o_busy               dump in progress
//   o_halt_req           freeze request to the core
//   i_halt_ack           core frozen, RF stable
//   o_rf_ren, o_rf_raddr debug RF read port; data returns on i_rf_rdata one
//                        cycle after o_rf_ren
//   o_dump_*             output stream (data, index, checksum marker, last)
//   i_dump_ready         stream back-pressure
//   o_done               1-cycle pulse after the checksum beat is taken
//   o_dbg_state          current FSM state, for checkers and debug
//
// Stream handshake: a beat transfers on every rising edge where o_dump_valid
// and i_dump_ready are both high. While valid is high and ready is low, data,
// idx, is_sum and last hold steady. Valid never drops without a transfer,
// except on reset.
module rf_dump_unit #(
    parameter int N_REGS = 32,
    parameter int XLEN   = 32,
    parameter int IDX_W  = 5
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_halt_req,
    input  logic             i_halt_ack,
    output logic             o_rf_ren,
    output logic [IDX_W-1:0] o_rf_raddr,
    input  logic [XLEN-1:0]  i_rf_rdata,
    output logic             o_dump_valid,
    input  logic             i_dump_ready,
    output logic [XLEN-1:0]  o_dump_data,
    output logic [IDX_W-1:0] o_dump_idx,
    output logic             o_dump_is_sum,
    output logic             o_dump_last,
    output logic             o_done,
    output logic [2:0]       o_dbg_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HALT_WAIT = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_CAPTURE   = 3'd3;
    localparam logic [2:0] S_SEND      = 3'd4;
    localparam logic [2:0] S_SEND_SUM  = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

    logic [2:0]       state;
    logic [IDX_W-1:0] cnt;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  beat;
    logic             accept;

    // x0 is hardwired zero architecturally, so whatever the port returns for
    // index 0 is ignored.
    assign beat        = (cnt == '0) ? '0 : i_rf_rdata;
    assign accept      = o_dump_valid && i_dump_ready;
    assign o_dbg_state = state;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            acc           <= '0;
            o_busy        <= 1'b0;
            o_halt_req    <= 1'b0;
            o_rf_ren      <= 1'b0;
            o_rf_raddr    <= '0;
            o_dump_valid  <= 1'b0;
            o_dump_data   <= '0;
            o_dump_idx    <= '0;
            o_dump_is_sum <= 1'b0;
            o_dump_last   <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state      <= S_HALT_WAIT;
                        cnt        <= '0;
                        acc        <= '0;
                        o_halt_req <= 1'b1;
                        o_busy     <= 1'b1;
                    end
                end
                S_HALT_WAIT: begin
                    // Enable is registered here so it is high exactly
                    // during the READ cycle.
                    if (i_halt_ack) begin
                        state      <= S_READ;
                        o_rf_ren   <= 1'b1;
                        o_rf_raddr <= cnt;
                    end
                end
                S_READ: begin
                    o_rf_ren <= 1'b0;
                    state    <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    o_dump_data  <= beat;
                    o_dump_idx   <= cnt;
                    o_dump_valid <= 1'b1;
                    acc          <= acc + beat;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    if (accept) begin
                        if (cnt == LAST_IDX) begin
                            // Valid stays high: the checksum beat follows
                            // the last register beat directly.
                            o_dump_data   <= acc;
                            o_dump_idx    <= '0;
                            o_dump_is_sum <= 1'b1;
                            o_dump_last   <= 1'b1;
                            state         <= S_SEND_SUM;
                        end else begin
                            o_dump_valid <= 1'b0;
                            cnt          <= cnt + 1'b1;
                            o_rf_ren     <= 1'b1;
                            o_rf_raddr   <= cnt + 1'b1;
                            state        <= S_READ;
                        end
                    end
                end
                S_SEND_SUM: begin
                    if (accept) begin
                        o_dump_valid  <= 1'b0;
                        o_dump_is_sum <= 1'b0;
                        o_dump_last   <= 1'b0;
                        o_dump_data   <= '0;
                        o_done        <= 1'b1;
                        o_halt_req    <= 1'b0;
                        o_busy        <= 1'b0;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
